// File: rtl/prco_lsu_if.sv
// prco_lsu bus bundle: request, local memory and response channels.
// master = LSU side, slave = pipeline/memory side.
interface prco_lsu_if;
  logic        i_req_valid;
  logic        q_req_ready;
  logic        i_req_we;
  logic [15:0] i_req_base;
  logic [7:0]  i_req_off;
  logic [15:0] i_req_data;
  logic [2:0]  i_req_rd;
  logic        q_mem_ce;
  logic        q_mem_we;
  logic [15:0] q_mem_addr;
  logic [15:0] q_mem_dina;
  logic [15:0] i_mem_douta;
  logic        q_rsp_valid;
  logic        i_rsp_ready;
  logic [15:0] q_rsp_data;
  logic [2:0]  q_rsp_rd;
  logic        q_rsp_we;
  logic        q_fault;

  modport master (
    input  i_req_valid, i_req_we, i_req_base,
    input  i_req_off, i_req_data, i_req_rd,
    input  i_mem_douta, i_rsp_ready,
    output q_req_ready,
    output q_mem_ce, q_mem_we, q_mem_addr, q_mem_dina,
    output q_rsp_valid, q_rsp_data, q_rsp_rd,
    output q_rsp_we, q_fault
  );

  modport slave (
    output i_req_valid, i_req_we, i_req_base,
    output i_req_off, i_req_data, i_req_rd,
    output i_mem_douta, i_rsp_ready,
    input  q_req_ready,
    input  q_mem_ce, q_mem_we, q_mem_addr, q_mem_dina,
    input  q_rsp_valid, q_rsp_data, q_rsp_rd,
    input  q_rsp_we, q_fault
  );
endinterface

// File: rtl/prco_lsu.sv
// prco_lsu: one-at-a-time LW/SW unit on the local memory port.
// Bounds-checks the word address and absorbs memory read latency.
module prco_lsu #(
  parameter int P_LMEM_WORDS  = 256,
  parameter int P_MEM_LATENCY = 1
) (
  input logic      i_clk,
  input logic      i_reset,
  prco_lsu_if.master lsu
);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, RESP
  } state_t;

  localparam logic [16:0] WORDS = 17'(P_LMEM_WORDS);
  localparam logic [3:0]  LAT   = 4'(P_MEM_LATENCY);

  state_t      state, state_nxt;
  logic [15:0] addr;
  logic        in_range;
  logic        accept;
  logic        last;
  logic        req_ready;
  logic        mem_ce;
  logic        rsp_valid;
  logic [3:0]  cnt;
  logic [15:0] mem_addr;
  logic [15:0] mem_dina;
  logic [15:0] rsp_data;
  logic [2:0]  rsp_rd;
  logic        rsp_we;
  logic        fault;

  assign addr = lsu.i_req_base
              + {{8{lsu.i_req_off[7]}}, lsu.i_req_off};
  assign in_range = {1'b0, addr} < WORDS;
  assign accept = lsu.i_req_valid & req_ready;
  assign last = cnt == 4'd1;

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    mem_ce    = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = ~i_reset;
        if (accept)
          state_nxt = in_range ? ISSUE : RESP;
      end
      ISSUE: begin
        mem_ce    = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (last) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (lsu.i_rsp_ready) state_nxt = IDLE;
      end
    endcase
  end

  // Memory-side registers only move for in-range accesses,
  // so the port holds the last issued address and data.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt      <= '0;
      mem_addr <= '0;
      mem_dina <= '0;
      rsp_data <= '0;
      rsp_rd   <= '0;
      rsp_we   <= 1'b0;
      fault    <= 1'b0;
    end else begin
      if (accept) begin
        rsp_rd <= lsu.i_req_rd;
        rsp_we <= lsu.i_req_we;
        if (in_range) begin
          mem_addr <= addr;
          mem_dina <= lsu.i_req_data;
          fault    <= 1'b0;
        end else begin
          fault    <= 1'b1;
          rsp_data <= '0;
        end
      end
      if (state == ISSUE) cnt <= LAT;
      if (state == WAIT) begin
        cnt <= cnt - 4'd1;
        if (last)
          rsp_data <= rsp_we ? mem_dina : lsu.i_mem_douta;
      end
    end
  end

  assign lsu.q_req_ready = req_ready;
  assign lsu.q_mem_ce    = mem_ce;
  assign lsu.q_mem_we    = mem_ce & rsp_we;
  assign lsu.q_mem_addr  = mem_addr;
  assign lsu.q_mem_dina  = mem_dina;
  assign lsu.q_rsp_valid = rsp_valid;
  assign lsu.q_rsp_data  = rsp_data;
  assign lsu.q_rsp_rd    = rsp_rd;
  assign lsu.q_rsp_we    = rsp_we;
  assign lsu.q_fault     = fault;

endmodule
